song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//   Playback controller for the note ROM: selects one of four songs, walks its
//   ROM entries, times each note in 1/128-note ticks and drives the tone output.
//   Adds play/pause/stop control, an end-of-song marker and an articulation gap.
//   Sits between the user-control debouncers and the tone-to-frequency divider.
// PARAMETERS
//   TICK_DIV    735000  clocks per 1/128-note tick (>=2)
//   GAP_TICKS   1       ticks at the end of each note forced silent (0 = legato)
//   ADDR_W      10      ROM address width
//   SONG0_BASE  0       first ROM address of song 0 (SONG1/2/3_BASE: 256/512/768)
// PORTS
//   clk        in   1       system clock
//   rst        in   1       asynchronous reset, active high
//   play       in   1       1-cycle pulse: start (IDLE) or resume (PAUSE)
//   pause      in   1       1-cycle pulse: freeze playback
//   stop       in   1       1-cycle pulse: abort to IDLE
//   song_sel   in   2       song index, sampled only when play starts from IDLE
//   rom_data   in   14      {dur[13:7], tone[6:0]}; valid 1 cycle after addr
//   addr       out  ADDR_W  ROM address (registered)
//   tone       out  7       current tone, 0 = silence (registered)
//   busy       out  1       high in FETCH/LOAD/PLAY/PAUSE
//   done       out  1       1-cycle pulse when end marker reached
// BEHAVIOUR
//   Reset: state IDLE, addr=0, tone=0, busy=0, done=0, all counters 0.
//   States: IDLE, FETCH, LOAD, PLAY, PAUSE.
//   Control priority when simultaneous: stop > pause > play.
//   IDLE: play -> addr<=SONGn_BASE[song_sel], go FETCH. pause/stop ignored.
//   FETCH (1 cycle): wait for synchronous ROM; tone=0. -> LOAD.
//   LOAD (1 cycle): capture rom_data. tone field 7'h7F = end marker -> done=1
//     for that one cycle, tone=0, go IDLE (addr holds). Else dur_q<=dur,
//     tone_q<=tone, tick_cnt=0, note_cnt=0 -> PLAY. stop here -> IDLE, no done.
//   PLAY: tick_cnt counts 0..TICK_DIV-1; on wrap note_cnt increments.
//     Note lasts exactly (dur_q+1)*TICK_DIV clocks in PLAY (dur 0 = 1 tick).
//     When tick_cnt==TICK_DIV-1 and note_cnt==dur_q: addr<=addr+1 -> FETCH.
//     tone = tone_q, except 0 while note_cnt > dur_q-GAP_TICKS (only when
//     dur_q+1 > GAP_TICKS; shorter notes play fully). tone_q=0 is a rest.
//   PAUSE: counters, addr, tone_q frozen; tone=0. play -> PLAY, resuming the
//     same cycle count; stop -> IDLE.
//   pause in PLAY -> PAUSE next cycle; pause in FETCH/LOAD is deferred and
//     taken on the first PLAY cycle. stop in any busy state -> IDLE next cycle,
//     tone=0, addr holds. play while busy and not paused: ignored.
//   addr increments modulo 2^ADDR_W (wrap 1023->0 with ADDR_W=10).
//   Counters: tick_cnt 32 bits, note_cnt 7 bits; width-safe compare, no
//     multiply in the datapath.
//   Reset asserted mid-note: immediate return to reset values, no done pulse.
//   Inter-note overhead: 2 clocks (FETCH, LOAD) of silence per note.
// TESTING  (TICK_DIV=4, GAP_TICKS=1)
//   ROM@0={dur 3,tone 12},@1=7F marker; play,song_sel=0 -> addr 0, tone 12 for
//     12 clocks, tone 0 for 4, addr 1, done pulse 2 cycles later, busy falls.
//   song_sel=2, play -> first addr=512; song_sel changed mid-song -> no effect.
//   dur 0 note, tone 5 -> tone 5 for 4 clocks (no gap), next FETCH on clock 4.
//   pause after 6 PLAY clocks, hold 20 clocks, play -> tone 0 while paused,
//     remaining 10 note clocks then FETCH; total PLAY clocks still 16.
//   stop+pause+play same cycle mid-note -> IDLE, tone 0, no done.
//   rst pulsed mid-note -> addr 0, tone 0, busy 0 immediately; play restarts.

Source files
------------

// File: rtl/song_sequencer.sv
// Song playback controller: walks a note ROM, times each note in ticks,
// and drives the tone output with play/pause/stop control.
module song_sequencer #(
    parameter int unsigned TICK_DIV   = 735000,
    parameter int unsigned GAP_TICKS  = 1,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned SONG0_BASE = 0,
    parameter int unsigned SONG1_BASE = 256,
    parameter int unsigned SONG2_BASE = 512,
    parameter int unsigned SONG3_BASE = 768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic [1:0]        song_sel,
    input  logic [13:0]       rom_data,
    output logic [ADDR_W-1:0] addr,
    output logic [6:0]        tone,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_PAUSE
    } state_t;

    state_t            r_state, w_state;
    logic [31:0]       r_tick, w_tick;
    logic [6:0]        r_note, w_note;
    logic [6:0]        r_dur, w_dur;
    logic [6:0]        r_toneq, w_toneq;
    logic              r_pend, w_pend;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [ADDR_W-1:0] w_base;
    logic [6:0]        r_tone, w_tone;
    logic              r_busy, r_done, w_done;
    logic              w_tick_end, w_note_end, w_pause_eff, w_gap;

    assign addr = r_addr;
    assign tone = r_tone;
    assign busy = r_busy;
    assign done = r_done;

    always_comb begin
        w_base = ADDR_W'(SONG0_BASE);
        unique case (song_sel)
            2'd0: w_base = ADDR_W'(SONG0_BASE);
            2'd1: w_base = ADDR_W'(SONG1_BASE);
            2'd2: w_base = ADDR_W'(SONG2_BASE);
            2'd3: w_base = ADDR_W'(SONG3_BASE);
        endcase
    end

    assign w_tick_end  = (r_tick == 32'(TICK_DIV - 1));
    assign w_note_end  = w_tick_end && (r_note == r_dur);
    assign w_pause_eff = pause | r_pend;

    always_comb begin
        w_state = r_state;
        w_tick  = r_tick;
        w_note  = r_note;
        w_dur   = r_dur;
        w_toneq = r_toneq;
        w_pend  = r_pend;
        w_addr  = r_addr;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (play) begin
                    w_addr  = w_base;
                    w_pend  = 1'b0;
                    w_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (stop) begin
                    w_state = S_IDLE;
                    w_pend  = 1'b0;
                end else begin
                    if (pause) w_pend = 1'b1;
                    w_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    w_state = S_IDLE;
                    w_pend  = 1'b0;
                end else if (rom_data[6:0] == 7'h7F) begin
                    w_done  = 1'b1;
                    w_pend  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    if (pause) w_pend = 1'b1;
                    w_dur   = rom_data[13:7];
                    w_toneq = rom_data[6:0];
                    w_tick  = '0;
                    w_note  = '0;
                    w_state = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_state = S_IDLE;
                    w_pend  = 1'b0;
                end else if (w_note_end) begin
                    // a pause landing on the last clock carries into the next note
                    w_addr  = r_addr + ADDR_W'(1);
                    w_pend  = w_pause_eff;
                    w_state = S_FETCH;
                end else begin
                    if (w_tick_end) begin
                        w_tick = '0;
                        w_note = r_note + 7'd1;
                    end else begin
                        w_tick = r_tick + 32'd1;
                    end
                    if (w_pause_eff) begin
                        w_pend  = 1'b0;
                        w_state = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_state = S_IDLE;
                    w_pend  = 1'b0;
                end else if (play) begin
                    w_state = S_PLAY;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // silence the last GAP_TICKS ticks, only when the note is longer than the gap
    assign w_gap = (32'(w_dur) + 32'd1 > 32'(GAP_TICKS))
                && (32'(w_note) + 32'(GAP_TICKS) > 32'(w_dur));

    always_comb begin
        w_tone = 7'd0;
        if (w_state == S_PLAY && !w_gap) w_tone = w_toneq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_note  <= '0;
            r_dur   <= '0;
            r_toneq <= '0;
            r_pend  <= 1'b0;
            r_addr  <= '0;
            r_tone  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_tick  <= w_tick;
            r_note  <= w_note;
            r_dur   <= w_dur;
            r_toneq <= w_toneq;
            r_pend  <= w_pend;
            r_addr  <= w_addr;
            r_tone  <= w_tone;
            r_busy  <= (w_state != S_IDLE);
            r_done  <= w_done;
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: a note-level reference model
// predicts addr/tone/busy/done each cycle; a monitor compares.
module tb_song_sequencer;
    localparam int TD  = 4;
    localparam int GAP = 1;
    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_LOAD  = 2;
    localparam int P_PLAY  = 3;
    localparam int P_PAUSE = 4;

    logic        clk = 1'b0;
    logic        rst, play, pause, stop;
    logic [1:0]  song_sel;
    logic [13:0] rom_data;
    logic [9:0]  addr;
    logic [6:0]  tone;
    logic        busy, done;

    song_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GAP)) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
        .song_sel(song_sel), .rom_data(rom_data), .addr(addr),
        .tone(tone), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [13:0] rom [1024];
    always_ff @(posedge clk) rom_data <= rom[addr];

    typedef struct packed {
        logic [9:0] a;
        logic [6:0] t;
        logic       b;
        logic       d;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    logic [1:0] sel_v = 2'd0;

    // reference model: phase plus clocks elapsed within the current note
    int ph, m_addr, m_dur, m_tone, m_el;
    bit m_pend, m_done;

    function automatic void m_reset();
        ph = P_IDLE; m_addr = 0; m_dur = 0; m_tone = 0;
        m_el = 0; m_pend = 0; m_done = 0;
    endfunction

    function automatic void m_step(bit pl, bit pa, bit st, int sel);
        logic [13:0] w;
        m_done = 0;
        case (ph)
            P_IDLE: if (pl) begin
                m_addr = sel * 256; m_pend = 0; ph = P_FETCH;
            end
            P_FETCH: if (st) begin ph = P_IDLE; m_pend = 0; end
                     else begin if (pa) m_pend = 1; ph = P_LOAD; end
            P_LOAD: begin
                w = rom[m_addr];
                if (st) begin ph = P_IDLE; m_pend = 0; end
                else if (w[6:0] == 7'h7F) begin
                    m_done = 1; m_pend = 0; ph = P_IDLE;
                end else begin
                    if (pa) m_pend = 1;
                    m_dur = int'(w[13:7]); m_tone = int'(w[6:0]);
                    m_el = 0; ph = P_PLAY;
                end
            end
            P_PLAY: if (st) begin ph = P_IDLE; m_pend = 0; end
            else begin
                m_el++;
                if (m_el == (m_dur + 1) * TD) begin
                    m_addr = (m_addr + 1) % 1024;
                    m_pend = pa | m_pend;
                    ph = P_FETCH;
                end else if (pa | m_pend) begin
                    m_pend = 0; ph = P_PAUSE;
                end
            end
            P_PAUSE: if (st) begin ph = P_IDLE; m_pend = 0; end
                     else if (pl) ph = P_PLAY;
            default: ph = P_IDLE;
        endcase
    endfunction

    function automatic exp_t m_out();
        exp_t e;
        e.a = 10'(m_addr);
        e.b = (ph != P_IDLE);
        e.d = m_done;
        e.t = 7'd0;
        if (ph == P_PLAY &&
            !((m_dur + 1 > GAP) && (m_el >= (m_dur + 1 - GAP) * TD)))
            e.t = 7'(m_tone);
        return e;
    endfunction

    task automatic step(bit pl = 0, bit pa = 0, bit st = 0);
        @(negedge clk);
        play = pl; pause = pa; stop = st; song_sel = sel_v;
        @(posedge clk);
        m_step(pl, pa, st, int'(sel_v));
        q.push_back(m_out());
    endtask

    task automatic chk(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic wait_idle(int maxc);
        int c = 0;
        while (c < maxc) begin
            step();
            #1;
            if (!busy) break;
            c++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL idle_timeout: busy=%0d after %0d cycles, want 0", busy, c);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (addr !== e.a || tone !== e.t || busy !== e.b || done !== e.d) begin
                    bad++;
                    $display("FAIL cycle t=%0t: addr=%0d tone=%0d busy=%0b done=%0b want addr=%0d tone=%0d busy=%0b done=%0b",
                             $time, addr, tone, busy, done, e.a, e.t, e.b, e.d);
                end
            end
        end
    end

    initial begin : stim
        int n12, nd;
        for (int i = 0; i < 1024; i++) rom[i] = 14'h007F;
        rom[0]   = {7'd3, 7'd12};
        rom[256] = {7'd0, 7'd5};
        for (int i = 257; i < 262; i++)
            rom[i] = {7'($urandom_range(0, 4)), 7'($urandom_range(0, 126))};
        for (int i = 512; i < 518; i++)
            rom[i] = {7'($urandom_range(0, 4)), 7'($urandom_range(0, 126))};
        rom[513] = {7'd2, 7'd0};
        for (int i = 768; i < 772; i++)
            rom[i] = {7'($urandom_range(0, 3)), 7'($urandom_range(1, 126))};

        rst = 1'b1; play = 0; pause = 0; stop = 0; song_sel = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_addr", int'(addr), 0);
        chk("reset_tone", int'(tone), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;

        // song 0: one 4-tick note then the end marker
        sel_v = 2'd0;
        step(1);
        n12 = 0; nd = 0;
        repeat (30) begin
            step();
            #1;
            if (tone == 7'd12) n12++;
            if (done) nd++;
        end
        chk("song0_tone12_clocks", n12, 12);
        chk("song0_done_pulses", nd, 1);

        // song 2 start address; song_sel change mid-song ignored
        sel_v = 2'd2;
        step(1);
        #1;
        chk("song2_first_addr", int'(addr), 512);
        sel_v = 2'd1;
        wait_idle(400);

        // song 1 begins with a dur-0 note
        sel_v = 2'd1;
        step(1);
        wait_idle(400);

        // pause on the 6th PLAY clock, hold, resume
        sel_v = 2'd0;
        step(1);
        repeat (7) step();
        step(0, 1, 0);
        repeat (20) step();
        step(1);
        wait_idle(100);

        // stop+pause+play together mid-note
        step(1);
        repeat (8) step();
        step(1, 1, 1);
        #1;
        chk("stop_all_busy", int'(busy), 0);
        chk("stop_all_tone", int'(tone), 0);
        repeat (3) step();

        // asynchronous reset mid-note
        step(1);
        repeat (6) step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_addr", int'(addr), 0);
        chk("midrst_tone", int'(tone), 0);
        chk("midrst_busy", int'(busy), 0);
        m_reset();
        @(posedge clk);
        q.push_back(m_out());
        @(negedge clk);
        rst = 1'b0;
        step(1);
        wait_idle(100);

        // random control pulses over random songs
        repeat (800) begin
            sel_v = 2'($urandom_range(0, 3));
            step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 59) == 0);
        end
        step(0, 0, 1);
        repeat (3) step();

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
